// File: rtl/pdu_rd_mover.sv
// Read-side PDU mover: owns the PDU freelist, turns CPU verdicts into DDR flit reads and
// steers the in-order responses to NUM_OUT output queues. Optional counters: PDU_RD_MOVER_STATS_EN.

module pdu_rd_mover_oq #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               sop_i,
  input  logic               eop_i,
  input  logic [EMPTY_W-1:0] empty_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               sop_o,
  output logic               eop_o,
  output logic [EMPTY_W-1:0] empty_o
);
  logic               valid_q, sop_q, eop_q, valid_d, sop_d, eop_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic [DATA_W-1:0]  data_q;

  // Framing is forced to zero on idle cycles so downstream can trust sop/eop alone.
  always_comb begin
    valid_d = push;
    sop_d   = push & sop_i;
    eop_d   = push & eop_i;
    empty_d = push ? empty_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else begin
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q <= data_i;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign empty_o = empty_q;
endmodule

module pdu_rd_mover #(
  parameter int PDUID_W   = 9,
  parameter int MAX_FLITS = 32,
  parameter int DATA_W    = 512,
  parameter int NUM_OUT   = 2,
  parameter int ADDR_W    = 25,
  parameter int TAG_DEPTH = 64,
  localparam int FLIT_W   = $clog2(MAX_FLITS),
  localparam int BYTES    = DATA_W / 8,
  localparam int EMPTY_W  = $clog2(BYTES),
  localparam int DEST_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        init_done,
  output logic [PDUID_W-1:0]          fl_data,
  output logic                        fl_valid,
  input  logic                        fl_ready,
  input  logic [PDUID_W-1:0]          vd_pdu_id,
  input  logic [FLIT_W:0]             vd_flits,
  input  logic [15:0]                 vd_size,
  input  logic [1:0]                  vd_action,
  input  logic [DEST_W-1:0]           vd_dest,
  input  logic                        vd_valid,
  output logic                        vd_ready,
  output logic [ADDR_W-1:0]           ddr_rd_req_addr,
  output logic                        ddr_rd_req_valid,
  input  logic                        ddr_rd_req_almost_full,
  input  logic [DATA_W-1:0]           ddr_rd_resp_data,
  input  logic                        ddr_rd_resp_valid,
  output logic                        ddr_rd_resp_ready,
  output logic [NUM_OUT*DATA_W-1:0]   out_data,
  output logic [NUM_OUT-1:0]          out_sop,
  output logic [NUM_OUT-1:0]          out_eop,
  output logic [NUM_OUT-1:0]          out_valid,
  output logic [NUM_OUT*EMPTY_W-1:0]  out_empty,
  input  logic [NUM_OUT-1:0]          out_almost_full,
  output logic                        err_len
`ifdef PDU_RD_MOVER_STATS_EN
  ,
  output logic [31:0]                 stat_fwd,
  output logic [31:0]                 stat_keep,
  output logic [31:0]                 stat_drop,
  output logic [31:0]                 stat_orphan,
  output logic [31:0]                 stat_flits
`endif
);
  localparam int TPTR_W = $clog2(TAG_DEPTH);
  localparam int TAG_W  = DEST_W + 2 + EMPTY_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE} state_e;

  // Async assert, 2-flop synchronised release.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e             state_q;
  logic [PDUID_W-1:0] init_cnt_q, pdu_id_q, fl_id_a_q, fl_wr_b_id_q;
  logic [FLIT_W:0]    flits_q, cnt_q;
  logic [15:0]        size_q;
  logic [DEST_W-1:0]  dest_q;
  logic               keep_q, init_done_q, err_len_q, fl_wr_a_q, fl_wr_b_q;

  logic [TPTR_W:0]    tag_cnt_q, tag_cnt_d;
  logic [TPTR_W-1:0]  tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
  logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_W-1:0]   tag_wdata, tag_head;
  logic               tag_valid, tag_afull, tag_push, tag_pop;
  logic [DEST_W-1:0]  hd_dest;
  logic               hd_sop, hd_eop;
  logic [EMPTY_W-1:0] hd_empty;

  logic               issue_fire, last_flit, vd_fire, vd_drop, vd_toolong, len_bad, resp_fire;
  logic [31:0]        pdu_bytes, slack;
  logic [EMPTY_W-1:0] tag_empty;

  assign tag_valid  = (tag_cnt_q != '0);
  assign tag_afull  = (tag_cnt_q >= (TPTR_W+1)'(TAG_DEPTH - 4));
  assign issue_fire = (state_q == S_ISSUE) & ~ddr_rd_req_almost_full & ~tag_afull
                    & ~out_almost_full[dest_q];
  assign last_flit  = (cnt_q == flits_q - 1'b1);
  assign vd_ready   = (state_q == S_IDLE) | (issue_fire & last_flit);
  assign vd_fire    = vd_valid & vd_ready;
  assign vd_toolong = (vd_flits > (FLIT_W+1)'(MAX_FLITS));
  assign vd_drop    = (vd_action == 2'd0) | (vd_action == 2'd3) | (vd_flits == '0) | vd_toolong;

  assign ddr_rd_req_valid = issue_fire;
  assign ddr_rd_req_addr  = ADDR_W'({pdu_id_q, cnt_q[FLIT_W-1:0]});

  // size must land in the last flit: (flits-1)*BYTES < size <= flits*BYTES
  assign pdu_bytes = 32'(flits_q) * 32'(BYTES);
  assign slack     = pdu_bytes - 32'(size_q);
  assign len_bad   = (32'(size_q) > pdu_bytes) | (32'(size_q) + 32'(BYTES) <= pdu_bytes);
  assign tag_empty = last_flit ? slack[EMPTY_W-1:0] : '0;
  assign tag_wdata = {dest_q, (cnt_q == '0), last_flit, tag_empty};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      err_len_q    <= 1'b0;
      fl_wr_a_q    <= 1'b0;
      fl_id_a_q    <= '0;
      fl_wr_b_q    <= 1'b0;
      fl_wr_b_id_q <= '0;
      pdu_id_q     <= '0;
      flits_q      <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      dest_q       <= '0;
      keep_q       <= 1'b0;
    end else begin
      fl_wr_a_q <= 1'b0;
      fl_wr_b_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (&init_cnt_q) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_ISSUE: if (issue_fire) begin
          cnt_q <= cnt_q + 1'b1;
          if (last_flit) begin
            if (len_bad) err_len_q <= 1'b1;
            fl_wr_a_q <= ~keep_q;
            fl_id_a_q <= pdu_id_q;
            state_q   <= S_IDLE;
          end
        end
        default: ;
      endcase
      // A back-to-back verdict on the last flit overrides the return to IDLE.
      if (vd_fire) begin
        if (vd_toolong) err_len_q <= 1'b1;
        if (vd_drop) begin
          fl_wr_b_q    <= 1'b1;
          fl_wr_b_id_q <= vd_pdu_id;
          state_q      <= S_IDLE;
        end else begin
          pdu_id_q <= vd_pdu_id;
          flits_q  <= vd_flits;
          size_q   <= vd_size;
          dest_q   <= vd_dest;
          keep_q   <= (vd_action == 2'd2);
          cnt_q    <= '0;
          state_q  <= S_ISSUE;
        end
      end
    end
  end

  assign init_done = init_done_q;
  assign err_len   = err_len_q;

  // Freelist: two write slots so a last-flit return and a back-to-back DROP coexist.
  logic [PDUID_W-1:0] fl_mem [2**PDUID_W];
  logic [PDUID_W-1:0] fl_rd_ptr_q, fl_rd_ptr_d, fl_wr_ptr_q, fl_wr_ptr_d, fl_id_a;
  logic [PDUID_W:0]   fl_cnt_q, fl_cnt_d;
  logic               fl_wr_a, fl_pop;

  assign fl_wr_a  = (state_q == S_INIT) | fl_wr_a_q;
  assign fl_id_a  = (state_q == S_INIT) ? init_cnt_q : fl_id_a_q;
  assign fl_valid = (fl_cnt_q != '0);
  assign fl_data  = fl_mem[fl_rd_ptr_q];
  assign fl_pop   = fl_valid & fl_ready;

  always_comb begin
    fl_rd_ptr_d = fl_rd_ptr_q + PDUID_W'(fl_pop);
    fl_wr_ptr_d = fl_wr_ptr_q + PDUID_W'(fl_wr_a) + PDUID_W'(fl_wr_b_q);
    fl_cnt_d    = fl_cnt_q + (PDUID_W+1)'(fl_wr_a) + (PDUID_W+1)'(fl_wr_b_q)
                - (PDUID_W+1)'(fl_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_rd_ptr_q <= '0;
      fl_wr_ptr_q <= '0;
      fl_cnt_q    <= '0;
    end else begin
      fl_rd_ptr_q <= fl_rd_ptr_d;
      fl_wr_ptr_q <= fl_wr_ptr_d;
      fl_cnt_q    <= fl_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fl_wr_a)   fl_mem[fl_wr_ptr_q] <= fl_id_a;
    if (fl_wr_b_q) fl_mem[fl_wr_ptr_q + PDUID_W'(fl_wr_a)] <= fl_wr_b_id_q;
  end

  // Tag FIFO mirrors outstanding DDR reads; responses return in order.
  assign tag_head = tag_mem[tag_rd_ptr_q];
  assign {hd_dest, hd_sop, hd_eop, hd_empty} = tag_head;
  assign tag_push = issue_fire;
  assign ddr_rd_resp_ready = rst_n & ddr_rd_resp_valid
                           & (~tag_valid | ~out_almost_full[hd_dest]);
  assign resp_fire = ddr_rd_resp_ready;
  assign tag_pop   = resp_fire & tag_valid;

  always_comb begin
    tag_wr_ptr_d = tag_wr_ptr_q + TPTR_W'(tag_push);
    tag_rd_ptr_d = tag_rd_ptr_q + TPTR_W'(tag_pop);
    tag_cnt_d    = tag_cnt_q + (TPTR_W+1)'(tag_push) - (TPTR_W+1)'(tag_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
    end else begin
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr_q] <= tag_wdata;
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_oq
    pdu_rd_mover_oq #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) u_oq (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (tag_pop & (hd_dest == DEST_W'(g))),
      .data_i  (ddr_rd_resp_data),
      .sop_i   (hd_sop),
      .eop_i   (hd_eop),
      .empty_i (hd_empty),
      .valid_o (out_valid[g]),
      .data_o  (out_data[g*DATA_W +: DATA_W]),
      .sop_o   (out_sop[g]),
      .eop_o   (out_eop[g]),
      .empty_o (out_empty[g*EMPTY_W +: EMPTY_W])
    );
  end

`ifdef PDU_RD_MOVER_STATS_EN
  logic [31:0] st_fwd_q, st_keep_q, st_drop_q, st_orph_q, st_flits_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_fwd_q   <= '0;
      st_keep_q  <= '0;
      st_drop_q  <= '0;
      st_orph_q  <= '0;
      st_flits_q <= '0;
    end else begin
      if (vd_fire & ~vd_drop & (vd_action == 2'd1)) st_fwd_q  <= st_fwd_q + 1'b1;
      if (vd_fire & ~vd_drop & (vd_action == 2'd2)) st_keep_q <= st_keep_q + 1'b1;
      if (vd_fire & vd_drop)                        st_drop_q <= st_drop_q + 1'b1;
      if (resp_fire & ~tag_valid)                   st_orph_q <= st_orph_q + 1'b1;
      if (tag_pop)                                  st_flits_q <= st_flits_q + 1'b1;
    end
  end
  assign stat_fwd    = st_fwd_q;
  assign stat_keep   = st_keep_q;
  assign stat_drop   = st_drop_q;
  assign stat_orphan = st_orph_q;
  assign stat_flits  = st_flits_q;
`endif
endmodule

// File: doc/pdu_rd_mover.md
# pdu_rd_mover

Parametrised read-side PDU mover for the check path. It owns the PDU buffer freelist and accepts per-PDU verdicts from the CPU. For each verdict it issues DDR flit reads and steers the returned flits to one of NUM_OUT output queues, where the original single-queue mover had only one. It adds a forward-and-keep mode, which forwards the PDU without releasing its buffer, and it applies backpressure per destination.

## Interface
Parameters:
- PDUID_W, 9: PDU id width; buffer count 2^PDUID_W.
- MAX_FLITS, 32: flits per PDU slot (power of two); FLIT_W = clog2(MAX_FLITS).
- DATA_W, 512: flit width; BYTES = DATA_W/8; EMPTY_W = clog2(BYTES).
- NUM_OUT, 2: output queues; DEST_W = max(1, clog2(NUM_OUT)).
- ADDR_W, 25: DDR flit address width (must be ≥ PDUID_W+FLIT_W).
- TAG_DEPTH, 64: in-flight read tag FIFO depth; almost-full at TAG_DEPTH-4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- init_done  out  1  freelist initialised.
- fl_data  out  PDUID_W  free PDU id to PDU generator.
- fl_valid  out  1  free id available.
- fl_ready  in  1  free id consumed.
- vd_pdu_id  in  PDUID_W  verdict PDU id.
- vd_flits  in  FLIT_W+1  PDU length in flits.
- vd_size  in  16  PDU length in bytes.
- vd_action  in  2  0=DROP, 1=FWD, 2=FWD_KEEP, 3=reserved (treated as DROP).
- vd_dest  in  DEST_W  destination queue.
- vd_valid  in  1  verdict valid.
- vd_ready  out  1  verdict accepted.
- ddr_rd_req_addr  out  ADDR_W  flit address.
- ddr_rd_req_valid  out  1  read request valid (push, no ready).
- ddr_rd_req_almost_full  in  1  stall request issue.
- ddr_rd_resp_data  in  DATA_W  read data, in order.
- ddr_rd_resp_valid  in  1  response valid.
- ddr_rd_resp_ready  out  1  response consumed.
- out_data  out  NUM_OUT×DATA_W  per-queue flit.
- out_sop, out_eop, out_valid  out  NUM_OUT each  per-queue framing/valid (push, no ready).
- out_empty  out  NUM_OUT×EMPTY_W  empty bytes on eop.
- out_almost_full  in  NUM_OUT  per-queue stall.
- err_len  out  1  sticky length error.

## Operation
- Issue FSM has three states: INIT, IDLE and ISSUE.
- **INIT**
  - Writes ids 0 … 2^PDUID_W−1 into the internal freelist FIFO, one id per cycle, in ascending order.
  - After the last write: init_done=1, go to IDLE.
  - vd_ready=0 throughout.
- **IDLE**
  - vd_ready=1.
  - On a verdict handshake, the verdict is latched.
  - DROP, reserved action, or vd_flits==0: the id is written to the freelist next cycle; stay in IDLE.
  - vd_flits > MAX_FLITS: set err_len and treat the verdict as DROP.
  - FWD or FWD_KEEP: flit counter cnt=0; go to ISSUE.
- **ISSUE**
  - A flit is issued when !ddr_rd_req_almost_full & !tag_almost_full & !out_almost_full[dest].
  - Each issued flit drives ddr_rd_req_addr = {pdu_id, cnt[FLIT_W-1:0]}, zero-extended to ADDR_W.
  - Each issued flit pushes a tag {dest, sop=(cnt==0), eop=(cnt==flits−1), empty}.
  - empty = (flits·BYTES − size) truncated to EMPTY_W on the eop flit, 0 otherwise.
  - If size > flits·BYTES or size ≤ (flits−1)·BYTES: set err_len; empty is still the truncated value.
  - On the last flit: FWD writes pdu_id to the freelist; FWD_KEEP does not.
  - On the last flit, vd_ready=1 combinationally, so a back-to-back verdict moves to ISSUE or IDLE without a gap.
- **Response path**
  - ddr_rd_resp_ready = ddr_rd_resp_valid & ((tag_valid & !out_almost_full[tag.dest]) | !tag_valid).
  - With a tag: the tag is popped, and the data, sop, eop and empty are registered onto queue tag.dest; all other queues have out_valid=0 that cycle.
  - Without a tag (orphan): the response is discarded.
- The freelist never overflows, because ids are unique. fl_valid=0 when the freelist is empty.
- err_len clears only on reset.

## Timing
- Reset values: init_done=0, fl_valid=0, vd_ready=0, ddr_rd_req_valid=0, ddr_rd_resp_ready=0, out_valid=0, out_sop=0, out_eop=0, out_empty=0, err_len=0, FSM=INIT, tag FIFO empty.
  - out_data and ddr_rd_req_addr have no reset.
- Reset is asserted asynchronously. Release is synchronised internally with 2 flops, so the first INIT write happens 2 cycles after deassertion.
- Reset mid-operation:
  - All in-flight state is lost and the freelist is re-initialised.
  - DDR responses that arrive afterwards are orphans and are discarded.
- INIT lasts exactly 2^PDUID_W cycles.
- Latencies:
  - Verdict handshake to first ddr_rd_req_valid: 1 cycle.
  - ISSUE with no stalls: 1 flit/cycle, so a FWD of N flits occupies N cycles.
  - DROP: 1 cycle per verdict.
  - Freelist write: 1 cycle after the DROP accept or the last-flit issue; visible on fl_valid 1 cycle after that.
  - Response accept to out_valid: 1 cycle.
- Stall cycles in ISSUE hold cnt and issue nothing (ddr_rd_req_valid=0).

## Configuration
- PDU_RD_MOVER_STATS_EN defined: the block adds outputs stat_fwd, stat_keep, stat_drop, stat_orphan and stat_flits, each 32 bits.
  - stat_fwd, stat_keep and stat_drop increment on the verdict accept.
  - stat_orphan increments on each discarded response.
  - stat_flits increments on each output flit.
  - Counters wrap modulo 2^32 and reset to 0.
- PDU_RD_MOVER_STATS_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- **Init:** release reset, PDUID_W=4 → init_done after 2+16 cycles; pop the freelist → ids 0..15 in order.
- **FWD, 3 flits:** id 5, size 130, dest 1 → addrs 160, 161, 162 on consecutive cycles; out[1] gets sop on flit 0, eop+empty=62 on flit 2; id 5 is returned to the freelist.
- **FWD_KEEP, id 7, 1 flit, size 64:** → one read at addr 224, sop=eop=1, empty=0; id 7 is not returned.
- **Backpressure:**
  - out_almost_full[0] held 10 cycles during a dest-0 PDU → no reads issued and no dest-0 responses accepted; resumes with no loss.
  - dest-1 traffic is unaffected on the response path.
- **Length errors:**
  - DROP id 9 → id 9 back in the freelist after 2 cycles, no reads.
  - vd_flits=40 → err_len=1, treated as DROP.
- **Orphan:** reset mid-PDU, then inject 2 responses → both accepted and discarded; no out_valid; stat_orphan=2 with PDU_RD_MOVER_STATS_EN defined.
